// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller for the fetch stage.
// Pushes link addresses (pc+4) on jal/jalr, predicts return targets on ret,
// exposes tos/cnt for backend checkpoints and restores them on mispredict.
// Optional build macro RAS_RESTORE_TOP_EN: a restore also rewrites
// entry[restore_tos] with restore_top, repairing wrong-path overwrites.
module ras_ctrl #(
  parameter int LG_DEPTH = 3,
  parameter int XLEN     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pd_valid,
  input  logic [3:0]          pd_type,
  input  logic [XLEN-1:0]     pd_pc,
  output logic                pd_ready,
  output logic                pred_valid,
  output logic [XLEN-1:0]     pred_target,
  output logic [LG_DEPTH-1:0] ckpt_tos,
  output logic [LG_DEPTH:0]   ckpt_cnt,
  input  logic                restore_valid,
  input  logic [LG_DEPTH-1:0] restore_tos,
  input  logic [LG_DEPTH:0]   restore_cnt,
  input  logic [XLEN-1:0]     restore_top
);

  localparam int DEPTH = 2 ** LG_DEPTH;

  localparam logic [3:0]          PD_RET   = 4'd2;
  localparam logic [3:0]          PD_JAL   = 4'd5;
  localparam logic [3:0]          PD_JALR  = 4'd6;
  localparam logic [LG_DEPTH-1:0] TOS_ONE  = LG_DEPTH'(1);
  localparam logic [LG_DEPTH:0]   CNT_ONE  = (LG_DEPTH + 1)'(1);
  localparam logic [LG_DEPTH:0]   CNT_FULL = (LG_DEPTH + 1)'(DEPTH);
  localparam logic [XLEN-1:0]     PC_STEP  = XLEN'(4);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [LG_DEPTH-1:0] tos_q;
  logic [LG_DEPTH:0]   cnt_q;
  logic [XLEN-1:0]     stack_mem [DEPTH];
  logic                accept;
  logic                do_push;
  logic                do_pop;
  logic [LG_DEPTH-1:0] tos_inc;

  assign tos_inc  = tos_q + TOS_ONE;
  assign ckpt_tos = tos_q;
  assign ckpt_cnt = cnt_q;

  // FSM state register: RESTORE blocks fetch for one cycle after a checkpoint load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state, handshake and push/pop decode; a restore drops any concurrent pd.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d  = state_q;
    pd_ready = 1'b0;
    case (state_q)
      ST_RUN:     pd_ready = 1'b1;
      ST_RESTORE: pd_ready = 1'b0;
      default:    pd_ready = 1'b0;
    endcase
    if (restore_valid)             state_d = ST_RESTORE;
    else if (state_q == ST_RESTORE) state_d = ST_RUN;
    accept  = pd_valid & pd_ready & ~restore_valid;
    do_push = accept & ((pd_type == PD_JAL) | (pd_type == PD_JALR));
    do_pop  = accept & (pd_type == PD_RET);
  end

  // Pointer, occupancy and registered prediction; restore outranks push/pop.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      tos_q       <= '0;
      cnt_q       <= '0;
      pred_valid  <= 1'b0;
      pred_target <= '0;
    end else if (restore_valid) begin
      tos_q      <= restore_tos;
      cnt_q      <= restore_cnt;
      pred_valid <= 1'b0;
    end else if (do_push) begin
      tos_q      <= tos_inc;
      cnt_q      <= (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_ONE;
      pred_valid <= 1'b0;
    end else if (do_pop) begin
      pred_valid <= 1'b1;
      if (cnt_q == '0) begin
        // Empty-stack miss: flag with a zero target and leave the stack alone.
        pred_target <= '0;
      end else begin
        pred_target <= stack_mem[tos_q];
        tos_q       <= tos_q - TOS_ONE;
        cnt_q       <= cnt_q - CNT_ONE;
      end
    end else begin
      pred_valid <= 1'b0;
    end
  end

  // Stack storage: circular buffer, the oldest entry is overwritten on overflow.
  always_ff @(posedge clk) begin
    // NOTE: the stack array has no reset; entries are only read while cnt says they are live.
`ifdef RAS_RESTORE_TOP_EN
    if (restore_valid) stack_mem[restore_tos] <= restore_top;
    else if (do_push)  stack_mem[tos_inc]     <= pd_pc + PC_STEP;
`else
    if (do_push) stack_mem[tos_inc] <= pd_pc + PC_STEP;
`endif
  end

`ifndef RAS_RESTORE_TOP_EN
  // restore_top only matters when top-entry repair is built in.
  logic unused_restore_top;
  assign unused_restore_top = ^restore_top;
`endif

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Return-address-stack controller for the fetch stage.
- Consumes per-instruction predecode control-flow class (4-bit code) plus fetch PC.
- Pushes link addresses on calls, pops predicted targets on returns, and exposes top-of-stack checkpoints to the backend.
- Restores its state from a checkpoint on branch mispredict or pipeline flush.

Parameters:
- LG_DEPTH, 3, log2 of stack entries (DEPTH = 2**LG_DEPTH = 8).
- XLEN, 64, address width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pd_valid  input  1  predecoded instruction presented this cycle
- pd_type  input  4  class: 0 none, 1 cond br, 2 ret, 3 j, 4 jr, 5 jal, 6 jalr
- pd_pc  input  XLEN  PC of the predecoded instruction
- pd_ready  output  1  controller accepts pd this cycle
- pred_valid  output  1  registered return prediction valid
- pred_target  output  XLEN  registered predicted return target
- ckpt_tos  output  LG_DEPTH  current top-of-stack pointer (for backend snapshot)
- ckpt_cnt  output  LG_DEPTH+1  current occupancy (for snapshot)
- restore_valid  input  1  backend restore request
- restore_tos  input  LG_DEPTH  checkpointed pointer
- restore_cnt  input  LG_DEPTH+1  checkpointed occupancy
- restore_top  input  XLEN  checkpointed top entry (used only with the optional feature)

Behaviour:
- Reset (async, active-high): tos=0, cnt=0, pred_valid=0, pred_target=0, state=RUN. pd_ready=1 after reset deasserts. Stack RAM contents are not reset.
- Accept = pd_valid & pd_ready.
- Push on accept when pd_type is 5 or 6: tos<=tos+1 (mod DEPTH); entry[tos+1]<=pd_pc+4 (XLEN wrap); cnt<=min(cnt+1, DEPTH).
  - Overflow overwrites the oldest entry (circular buffer); cnt saturates at DEPTH.
- Pop on accept when pd_type is 2:
  - Next cycle: pred_valid=1, pred_target=entry[tos].
  - tos<=tos-1 (mod DEPTH); cnt<=cnt-1.
- Pop with cnt==0: pred_valid=1 and pred_target=0 next cycle, flagging an empty-stack miss. tos and cnt are unchanged.
- Other types (0,1,3,4): no stack change. pred_valid=0 next cycle.
- pred_valid is a 1-cycle pulse, latency exactly 1 cycle from the accepted pop.
- State machine (RUN, RESTORE):
  - RUN --restore_valid--> RESTORE.
  - In the cycle restore_valid is sampled: tos<=restore_tos, cnt<=restore_cnt; any concurrent pd push/pop is dropped; pred_valid<=0.
  - RESTORE: pd_ready=0 for exactly one cycle, then returns to RUN.
  - restore_valid asserted again while in RESTORE re-applies the new checkpoint and stays in RESTORE one more cycle.
- Priority: reset > restore_valid > pd push/pop.
- ckpt_tos and ckpt_cnt are the registered values (pre-update) in the current cycle.
- Asserting reset mid-RESTORE returns to RUN with empty stack.

Optional Feature:
- Macro RAS_RESTORE_TOP_EN.
- Defined: on restore, entry[restore_tos]<=restore_top as well, repairing an entry overwritten by wrong-path pushes.
- Undefined: restore_top is ignored; only tos and cnt are restored.

Test Plan:
- Reset then pd jal pd_pc=0x1000, then ret -> cycle after ret: pred_valid=1, pred_target=0x1004; cnt back to 0.
- Three pushes (jalr 0x100, 0x200, 0x300) then three rets -> targets 0x304, 0x204, 0x104 in order; a fourth ret gives pred_valid=1, pred_target=0, tos unchanged.
- Nine jal pushes (PCs 0x0..0x20, step 4) -> cnt saturates at 8; eight rets return 0x24 down to 0x8; the 9th ret is an empty miss.
- Push 0xA000, snapshot (tos=1, cnt=1), push 0xB000, ret, ret, restore(tos=1, cnt=1) concurrent with a jal -> jal dropped, pd_ready=0 one cycle, next ret predicts 0xA004.
  - With RAS_RESTORE_TOP_EN: same result even after a wrong-path push clobbers entry 1, when restore_top=0xA004.
- pd types 0,1,3,4 stream interleaved with one ret and an empty stack -> only the ret produces pred_valid; tos stays 0.
- Async reset asserted mid-RESTORE and between clock edges -> outputs zero immediately; pd_ready=1 after release.
